// File: rtl/cdb_arbiter.sv
// cdb_arbiter: four-way common-data-bus arbiter (int, mult, div, mem).
// Grants are combinational. The CDB outputs are registered, so a grant in
// cycle T becomes visible on the bus in cycle T+1.
// Build option CDB_ARB_ROUND_ROBIN_EN:
//   - defined: round-robin arbitration starting at o_ptr.
//   - undefined (default): fixed priority mult > mem > div > int, with o_ptr held at 0.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_int_req,
    input  logic [TAG_W-1:0]  i_int_tag,
    input  logic [DATA_W-1:0] i_int_data,
    input  logic              i_int_branch,
    input  logic              i_int_branch_taken,
    input  logic              i_mult_req,
    input  logic [TAG_W-1:0]  i_mult_tag,
    input  logic [DATA_W-1:0] i_mult_data,
    input  logic              i_div_req,
    input  logic [TAG_W-1:0]  i_div_tag,
    input  logic [DATA_W-1:0] i_div_data,
    input  logic              i_mem_req,
    input  logic [TAG_W-1:0]  i_mem_tag,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_int_grant,
    output logic              o_mult_grant,
    output logic              o_div_grant,
    output logic              o_mem_grant,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_branch_taken,
    output logic [1:0]        o_ptr
);

    // Unit index: 0=int, 1=mult, 2=div, 3=mem
    logic [3:0]        req;
    logic [3:0]        grant;
    logic [TAG_W-1:0]  tag_arr  [4];
    logic [DATA_W-1:0] data_arr [4];

    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              found;
    logic              any_grant;

    logic              valid_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [DATA_W-1:0] data_reg;
    logic              branch_reg;
    logic              taken_reg;
    logic [1:0]        ptr_reg;

    assign req         = {i_mem_req, i_div_req, i_mult_req, i_int_req};
    assign tag_arr[0]  = i_int_tag;
    assign tag_arr[1]  = i_mult_tag;
    assign tag_arr[2]  = i_div_tag;
    assign tag_arr[3]  = i_mem_tag;
    assign data_arr[0] = i_int_data;
    assign data_arr[1] = i_mult_data;
    assign data_arr[2] = i_div_data;
    assign data_arr[3] = i_mem_data;

    // Pick the single winner. Reset suppresses every grant, which discards a transfer still pending.
    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        found  = 1'b0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        for (int off = 0; off < 4; off++) begin
            idx = ptr_reg + 2'(off);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
`else
        if (req[1]) begin
            found  = 1'b1;
            winner = 2'd1;
        end else if (req[3]) begin
            found  = 1'b1;
            winner = 2'd3;
        end else if (req[2]) begin
            found  = 1'b1;
            winner = 2'd2;
        end else if (req[0]) begin
            found  = 1'b1;
            winner = 2'd0;
        end
`endif
        any_grant = found && !i_rst;
    end

    // Decode the winner into a one-hot grant vector.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grant
            assign grant[gi] = any_grant && (winner == 2'(gi));
        end
    endgenerate

    assign o_int_grant  = grant[0];
    assign o_mult_grant = grant[1];
    assign o_div_grant  = grant[2];
    assign o_mem_grant  = grant[3];

    // CDB register stage plus pointer. When there is no grant, the payload fields hold their last values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg  <= 1'b0;
            tag_reg    <= '0;
            data_reg   <= '0;
            branch_reg <= 1'b0;
            taken_reg  <= 1'b0;
            ptr_reg    <= 2'd0;
        end else begin
            valid_reg <= any_grant;
            if (any_grant) begin
                tag_reg    <= tag_arr[winner];
                data_reg   <= data_arr[winner];
                branch_reg <= (winner == 2'd0) && i_int_branch;
                taken_reg  <= (winner == 2'd0) && i_int_branch_taken;
`ifdef CDB_ARB_ROUND_ROBIN_EN
                ptr_reg    <= winner + 2'd1;
`endif
            end
`ifndef CDB_ARB_ROUND_ROBIN_EN
            ptr_reg <= 2'd0;
`endif
        end
    end

    assign cdb_valid        = valid_reg;
    assign cdb_tag          = tag_reg;
    assign cdb_data         = data_reg;
    assign cdb_branch       = branch_reg;
    assign cdb_branch_taken = taken_reg;
    assign o_ptr            = ptr_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter. Expected values follow the
// CDB_ARB_ROUND_ROBIN_EN build option, so the bench works in either build.
module tb_cdb_arbiter;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [5:0]  tag  [4];
    logic [31:0] data [4];
    logic        br;
    logic        br_taken;

    logic        g_int, g_mult, g_div, g_mem;
    logic        cdb_valid, cdb_branch, cdb_branch_taken;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  ptr;

    int total  = 0;
    int passed = 0;

    cdb_arbiter #(.DATA_W(32), .TAG_W(6)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_int_req(req[0]),  .i_int_tag(tag[0]),  .i_int_data(data[0]),
        .i_int_branch(br),   .i_int_branch_taken(br_taken),
        .i_mult_req(req[1]), .i_mult_tag(tag[1]), .i_mult_data(data[1]),
        .i_div_req(req[2]),  .i_div_tag(tag[2]),  .i_div_data(data[2]),
        .i_mem_req(req[3]),  .i_mem_tag(tag[3]),  .i_mem_data(data[3]),
        .o_int_grant(g_int), .o_mult_grant(g_mult),
        .o_div_grant(g_div), .o_mem_grant(g_mem),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
        .o_ptr(ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    task automatic check_grants(input string name, input logic [3:0] exp);
        #1;
        check(name, {60'd0, g_mem, g_div, g_mult, g_int}, {60'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cdb(input string name, input logic v, input logic [5:0] t,
                             input logic [31:0] d, input logic b, input logic bt,
                             input logic [1:0] p);
        check({name, "_cdb"}, {22'd0, cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken, ptr},
              {22'd0, v, t, d, b, bt, p});
    endtask

    initial begin
        logic [1:0] w;
        logic [1:0] w1;
        logic [1:0] w2;
        rst = 1'b1; req = 4'b1111; br = 1'b0; br_taken = 1'b0;
        for (int u = 0; u < 4; u++) begin
            tag[u]  = 6'(8 + u);
            data[u] = 32'h5000_0000 + u;
        end

        // Reset for 2 cycles with every request high: no grants.
        check_grants("rst_grant0", 4'b0000);
        tick();
        check_cdb("rst_c1", 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 2'd0);
        check_grants("rst_grant1", 4'b0000);
        tick();
        check_cdb("rst_c2", 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0; req = 4'b0000;
        check_grants("idle_grant", 4'b0000);
        tick();
        check_cdb("idle_c1", 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 2'd0);
        tick();
        check_cdb("idle_c2", 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 2'd0);

        // Single div requester.
        req = 4'b0100; tag[2] = 6'h15; data[2] = 32'hDEADBEEF;
        check_grants("div_grant", 4'b0100);
        tick();
        check_cdb("div", 1'b1, 6'h15, 32'hDEADBEEF, 1'b0, 1'b0, RR ? 2'd3 : 2'd0);
        req = 4'b0000;
        check_grants("div_idle_grant", 4'b0000);
        tick();
        check_cdb("div_idle_hold", 1'b0, 6'h15, 32'hDEADBEEF, 1'b0, 1'b0, RR ? 2'd3 : 2'd0);

        // Reset pulse to bring the pointer back to 0, then all four request for 8 cycles.
        rst = 1'b1;
        tick();
        check_cdb("rst_pulse", 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int u = 0; u < 4; u++) begin
                tag[u]  = 6'(8 + u);
                data[u] = 32'hA000_0000 | (u << 8) | c;
            end
            w = RR ? 2'(c % 4) : 2'd1;
            check_grants($sformatf("all_grant_%0d", c), 4'b0001 << w);
            tick();
            check_cdb($sformatf("all_%0d", c), 1'b1, 6'(8 + w),
                      32'hA000_0000 | (32'(w) << 8) | 32'(c), 1'b0, 1'b0,
                      RR ? w + 2'd1 : 2'd0);
        end
        req = 4'b0000;
        tick();

        // Int branch (taken) alongside mem, with the pointer at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1001; tag[0] = 6'h02; data[0] = 32'h0000_0B0B;
        tag[3] = 6'h33; data[3] = 32'hCAFEF00D;
        br = 1'b1; br_taken = 1'b1;
        w1 = RR ? 2'd0 : 2'd3;
        w2 = RR ? 2'd3 : 2'd0;
        check_grants("br_grant1", 4'b0001 << w1);
        tick();
        check_cdb("br_first", 1'b1, tag[w1], data[w1], w1 == 2'd0, w1 == 2'd0,
                  RR ? w1 + 2'd1 : 2'd0);
        req[w1] = 1'b0;
        check_grants("br_grant2", 4'b0001 << w2);
        tick();
        check_cdb("br_second", 1'b1, tag[w2], data[w2], w2 == 2'd0, w2 == 2'd0,
                  RR ? w2 + 2'd1 : 2'd0);
        req = 4'b0000; br = 1'b0; br_taken = 1'b0;
        tick();
        check_cdb("br_idle", 1'b0, tag[w2], data[w2], w2 == 2'd0, w2 == 2'd0,
                  RR ? w2 + 2'd1 : 2'd0);

        // mult, mem and int together; each requester drops its request once granted.
        // Fixed priority order: mult, mem, int. Round-robin from pointer 0: int, mult, mem.
        req = 4'b1011;
        tag[0] = 6'h20; tag[1] = 6'h21; tag[3] = 6'h23;
        data[0] = 32'h1111_0000; data[1] = 32'h2222_0000; data[3] = 32'h4444_0000;
        for (int s = 0; s < 3; s++) begin
            if (RR) w = (s == 0) ? 2'd0 : (s == 1) ? 2'd1 : 2'd3;
            else    w = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : 2'd0;
            check_grants($sformatf("prio_grant_%0d", s), 4'b0001 << w);
            tick();
            check_cdb($sformatf("prio_%0d", s), 1'b1, tag[w], data[w], 1'b0, 1'b0,
                      RR ? w + 2'd1 : 2'd0);
            req[w] = 1'b0;
        end
        check_grants("prio_done_grant", 4'b0000);
        tick();

        // Reset during the cycle mult is granted; mult keeps its request asserted.
        req = 4'b0010; tag[1] = 6'h2A; data[1] = 32'h0BAD_F00D;
        check_grants("mid_grant_pre", 4'b0010);
        rst = 1'b1;
        check_grants("mid_grant_rst", 4'b0000);
        tick();
        check_cdb("mid_rst", 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        check_grants("mid_regrant", 4'b0010);
        tick();
        check_cdb("mid_once", 1'b1, 6'h2A, 32'h0BAD_F00D, 1'b0, 1'b0, RR ? 2'd2 : 2'd0);
        req = 4'b0000;
        tick();
        check_cdb("mid_after", 1'b0, 6'h2A, 32'h0BAD_F00D, 1'b0, 1'b0, RR ? 2'd2 : 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
